// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and encodings for the ALU issue controller.
// The ALU_ISSUE_SHIFT_EN macro adds the SHIFT state.
package alu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    AluOpAnd = 3'b000,
    AluOpOr  = 3'b001,
    AluOpAdd = 3'b010
  } alu_op_e;

  localparam logic [3:0] FuncAnd = 4'd0;
  localparam logic [3:0] FuncOr  = 4'd1;
  localparam logic [3:0] FuncAdd = 4'd2;
  localparam logic [3:0] FuncSub = 4'd6;
  localparam logic [3:0] FuncSlt = 4'd7;
  localparam logic [3:0] FuncNor = 4'd12;
  localparam logic [3:0] FuncSll = 4'd8;
  localparam logic [3:0] FuncSrl = 4'd9;

  typedef struct packed {
    alu_op_e op;
    logic    ainvert;
    logic    bnegate;
    logic    cin;
    logic    legal;
    logic    is_shift;
  } alu_ctrl_t;

`ifdef ALU_ISSUE_SHIFT_EN
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StExec  = 2'd1,
    StResp  = 2'd2,
    StShift = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive/return and response signals of the ALU issue controller.
// slave: the controller; master: the environment (requester, ALU, consumer).
interface alu_issue_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_func;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_shamt;

  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic        alu_ainvert;
  logic        alu_bnegate;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_overflow;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_cout;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_func, req_a, req_b, req_shamt,
    input  alu_result, alu_cout, alu_overflow,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_op,
    output rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_cout, rsp_err
  );

  modport master (
    output req_valid, req_func, req_a, req_b, req_shamt,
    output alu_result, alu_cout, alu_overflow,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_op,
    input  rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_cout, rsp_err
  );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational function-code decode into ALU controls plus legal/shift flags.
// Shift codes are legal only when ALU_ISSUE_SHIFT_EN is defined.
module alu_func_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] func_i,
  output alu_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o    = '0;
    ctrl_o.op = AluOpAnd;
    case (func_i)
      FuncAnd: ctrl_o.legal = 1'b1;
      FuncOr: begin
        ctrl_o.op    = AluOpOr;
        ctrl_o.legal = 1'b1;
      end
      FuncAdd: begin
        ctrl_o.op    = AluOpAdd;
        ctrl_o.legal = 1'b1;
      end
      FuncSub, FuncSlt: begin
        ctrl_o.op      = AluOpAdd;
        ctrl_o.bnegate = 1'b1;
        ctrl_o.cin     = 1'b1;
        ctrl_o.legal   = 1'b1;
      end
      // NOR via De Morgan: ~a & ~b
      FuncNor: begin
        ctrl_o.ainvert = 1'b1;
        ctrl_o.bnegate = 1'b1;
        ctrl_o.legal   = 1'b1;
      end
`ifdef ALU_ISSUE_SHIFT_EN
      FuncSll, FuncSrl: begin
        ctrl_o.legal    = 1'b1;
        ctrl_o.is_shift = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to an external combinational ALU and returns a
// flagged response. Define ALU_ISSUE_SHIFT_EN to enable iterative SLL/SRL.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input logic             clk,
  input logic             reset,
  alu_issue_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  alu_ctrl_t   ctrl, ctrl_q;
  logic [15:0] a_q, b_q;
  logic [3:0]  func_q;
  logic [15:0] res_q, res_d;
  logic        zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d, err_q, err_d;
  logic        accept, capture, exec_legal;
`ifdef ALU_ISSUE_SHIFT_EN
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        shift_last;
`endif

  alu_func_decode u_decode (
    .func_i (bus.req_func),
    .ctrl_o (ctrl)
  );

  assign accept = bus.req_valid && bus.req_ready;

`ifdef ALU_ISSUE_SHIFT_EN
  assign exec_legal = ctrl_q.legal;
`else
  assign exec_legal = ctrl_q.legal && !ctrl_q.is_shift;
`endif

  always_comb begin
    state_d         = state_q;
    capture         = 1'b0;
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_cin     = 1'b0;
    bus.alu_ainvert = 1'b0;
    bus.alu_bnegate = 1'b0;
    bus.alu_op      = AluOpAnd;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
`ifdef ALU_ISSUE_SHIFT_EN
          state_d = ctrl.is_shift ? StShift : StExec;
`else
          state_d = StExec;
`endif
        end
      end
      StExec: begin
        bus.alu_a       = a_q;
        bus.alu_b       = b_q;
        bus.alu_cin     = ctrl_q.cin;
        bus.alu_ainvert = ctrl_q.ainvert;
        bus.alu_bnegate = ctrl_q.bnegate;
        bus.alu_op      = ctrl_q.op;
        capture         = 1'b1;
        state_d         = StResp;
      end
`ifdef ALU_ISSUE_SHIFT_EN
      StShift: begin
        // Left shift by one is acc + acc on the ALU; right shift is local
        if (func_q == FuncSll) begin
          bus.alu_a  = acc_q;
          bus.alu_b  = acc_q;
          bus.alu_op = AluOpAdd;
        end
        if (shift_last) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
`endif
      StResp: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ALU_ISSUE_SHIFT_EN
  // cnt_q holds remaining shifts; shamt=0 still spends one cycle with acc untouched
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      acc_d = (func_q == FuncSll) ? bus.alu_result : {1'b0, acc_q[15:1]};
    end
  end

  assign shift_last = (cnt_q <= 4'd1);
`endif

  always_comb begin
    res_d  = bus.alu_result;
    ovf_d  = 1'b0;
    cout_d = 1'b0;
    err_d  = 1'b0;
    if (!exec_legal) begin
      res_d = '0;
      err_d = 1'b1;
    end else if (func_q == FuncSlt) begin
      res_d = {15'b0, bus.alu_result[15] ^ bus.alu_overflow};
    end else if (func_q == FuncAdd || func_q == FuncSub) begin
      ovf_d  = bus.alu_overflow;
      cout_d = bus.alu_cout;
    end
`ifdef ALU_ISSUE_SHIFT_EN
    if (state_q == StShift) res_d = acc_d;
`endif
    zero_d = !err_d && (res_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_ISSUE_SHIFT_EN
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= bus.req_a;
        b_q    <= bus.req_b;
        func_q <= bus.req_func;
        ctrl_q <= ctrl;
`ifdef ALU_ISSUE_SHIFT_EN
        acc_q  <= bus.req_a;
        cnt_q  <= bus.req_shamt;
`endif
      end
`ifdef ALU_ISSUE_SHIFT_EN
      if (state_q == StShift) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
`endif
      if (capture) begin
        res_q  <= res_d;
        zero_q <= zero_d;
        ovf_q  <= ovf_d;
        cout_q <= cout_d;
        err_q  <= err_d;
      end
    end
  end

  assign bus.rsp_result   = res_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_cout     = cout_q;
  assign bus.rsp_err      = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural combinational ALU.
// Shift expectations follow ALU_ISSUE_SHIFT_EN.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        zero;
    logic        ovf;
    logic        cout;
    logic        err;
  } exp_t;

`ifdef ALU_ISSUE_SHIFT_EN
  localparam bit ShiftEn = 1'b1;
`else
  localparam bit ShiftEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rsp_idx = 0;
  int   lat;
  exp_t expq[$];
  exp_t mon_e;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: flags always come from the adder so masking is observable
  logic [15:0] ma, mb;
  logic [16:0] msum;
  always_comb begin
    ma   = bus.alu_ainvert ? ~bus.alu_a : bus.alu_a;
    mb   = bus.alu_bnegate ? ~bus.alu_b : bus.alu_b;
    msum = {1'b0, ma} + {1'b0, mb} + {16'b0, bus.alu_cin};
    case (bus.alu_op)
      3'b000:  bus.alu_result = ma & mb;
      3'b001:  bus.alu_result = ma | mb;
      3'b010:  bus.alu_result = msum[15:0];
      default: bus.alu_result = '0;
    endcase
    bus.alu_cout     = msum[16];
    bus.alu_overflow = (ma[15] == mb[15]) && (msum[15] != ma[15]);
  end

  function automatic exp_t mk(logic [15:0] r, logic z, logic o, logic c, logic e);
    mk = '{res: r, zero: z, ovf: o, cout: c, err: e};
  endfunction

  function automatic exp_t shf(logic [15:0] r);
    shf = ShiftEn ? mk(r, r == 16'h0, 1'b0, 1'b0, 1'b0) : mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got result 0x%0h, want no response", bus.rsp_result);
      end else begin
        mon_e = expq.pop_front();
        chk($sformatf("rsp%0d", rsp_idx),
            {bus.rsp_result, bus.rsp_zero, bus.rsp_overflow, bus.rsp_cout, bus.rsp_err}, mon_e);
      end
      rsp_idx++;
    end
  end

  task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] sh, input bit push, input exp_t e);
    bus.req_func  = f;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_shamt = sh;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (push) expq.push_back(e);
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: got req_ready 0, want 1 within 60 cycles");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (expq.size() == 0 && bus.req_ready) return;
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got %0d pending responses, want 0", expq.size());
  endtask

  // Edges from the accepting edge until rsp_valid is seen
  task automatic measure(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_overflow,
                        bus.rsp_cout, bus.rsp_err}, 0);
    chk({tag, "_alu"}, {bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_ainvert, bus.alu_bnegate,
                        bus.alu_op}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000 time units");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_func  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_shamt = '0;
    bus.rsp_ready = 1'b1;
    #1;
    chk_reset_vals("reset");
    #10;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ADD overflow case and two-edge latency
    send(FuncAdd, 16'h7FFF, 16'h0001, 4'd0, 1'b1, mk(16'h8000, 0, 1, 0, 0));
    chk("add_lat_edge1", bus.rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("add_lat_edge2", bus.rsp_valid, 1);
    wait_idle();

    send(FuncSub, 16'h0005, 16'h0005, 4'd0, 1'b1, mk(16'h0000, 1, 0, 1, 0));
    send(FuncSlt, 16'h8000, 16'h0001, 4'd0, 1'b1, mk(16'h0001, 0, 0, 0, 0));
    send(FuncAnd, 16'hF0F0, 16'hFF00, 4'd0, 1'b1, mk(16'hF000, 0, 0, 0, 0));
    send(FuncOr,  16'h00F0, 16'h0F00, 4'd0, 1'b1, mk(16'h0FF0, 0, 0, 0, 0));
    send(FuncNor, 16'h00FF, 16'h0F00, 4'd0, 1'b1, mk(16'hF000, 0, 0, 0, 0));
    send(FuncNor, 16'hFFFF, 16'h0000, 4'd0, 1'b1, mk(16'h0000, 1, 0, 0, 0));
    send(FuncAdd, 16'hFFFF, 16'h0001, 4'd0, 1'b1, mk(16'h0000, 1, 0, 1, 0));
    send(4'd3,    16'h1234, 16'h5678, 4'd0, 1'b1, mk(16'h0000, 0, 0, 0, 1));
    send(4'd15,   16'hAAAA, 16'h5555, 4'd0, 1'b1, mk(16'h0000, 0, 0, 0, 1));
    wait_idle();

    // Shifts: iteration count shows up as response latency
    send(FuncSll, 16'h0003, 16'h0000, 4'd4, 1'b1, shf(16'h0030));
    measure(lat);
    chk("sll4_latency", lat, ShiftEn ? 4 : 1);
    wait_idle();
    send(FuncSrl, 16'h8000, 16'h0000, 4'd15, 1'b1, shf(16'h0001));
    measure(lat);
    chk("srl15_latency", lat, ShiftEn ? 15 : 1);
    wait_idle();
    send(FuncSll, 16'h1234, 16'h0000, 4'd0, 1'b1, shf(16'h1234));
    measure(lat);
    chk("sll0_latency", lat, 1);
    wait_idle();
    send(FuncSll, 16'h8001, 16'h0000, 4'd1, 1'b1, shf(16'h0002));
    send(FuncSrl, 16'h0001, 16'h0000, 4'd1, 1'b1, shf(16'h0000));
    wait_idle();

    // Back-pressure: response held while rsp_ready is low
    bus.rsp_ready = 1'b0;
    send(FuncAdd, 16'h0001, 16'h0002, 4'd0, 1'b1, mk(16'h0003, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d", i),
          {bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_zero, bus.rsp_overflow,
           bus.rsp_cout, bus.rsp_err}, {1'b1, 1'b0, 16'h0003, 4'b0000});
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    wait_idle();

    // Leave a non-zero response behind, then reset mid-operation
    send(FuncOr, 16'h00F0, 16'h0F00, 4'd0, 1'b1, mk(16'h0FF0, 0, 0, 0, 0));
    wait_idle();
    send(FuncSll, 16'h0001, 16'h0000, 4'd10, 1'b0, '0);
    if (ShiftEn) begin
      repeat (3) @(posedge clk);
      #1;
    end
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("midop_reset");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("in_reset_no_rsp", bus.rsp_valid, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_no_rsp", bus.rsp_valid, 0);
    send(FuncAdd, 16'h1111, 16'h2222, 4'd0, 1'b1, mk(16'h3333, 0, 0, 0, 0));
    wait_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; reset input 1, asynchronous active-high.
REQ-002 SHALL have request ports: req_valid in 1; req_ready out 1; req_func in 4 (function code); req_a in 16; req_b in 16; req_shamt in 4 (shift amount).
REQ-003 SHALL have ALU-drive ports: alu_a out 16; alu_b out 16; alu_cin out 1; alu_ainvert out 1; alu_bnegate out 1; alu_op out 3.
REQ-004 SHALL have ALU-return ports: alu_result in 16; alu_cout in 1; alu_overflow in 1. The ALU is combinational, same cycle.
REQ-005 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_result out 16; rsp_zero out 1; rsp_overflow out 1; rsp_cout out 1; rsp_err out 1 (illegal function).

Function
REQ-006 SHALL decode req_func as: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR, 8 SLL, 9 SRL; all other codes are illegal.
REQ-007 SHALL drive ALU controls per op: AND op=000; OR op=001; ADD op=010 cin=0; SUB/SLT op=010, bnegate=1, cin=1; NOR op=000, ainvert=1, bnegate=1; ainvert/bnegate/cin=0 otherwise.
REQ-008 SHALL use FSM states IDLE, EXEC, SHIFT, RESP.
REQ-009 SHALL assert req_ready only in IDLE; a request is accepted on a clk edge with req_valid and req_ready both 1; operands, func and shamt are registered on that edge.
REQ-010 IDLE -> EXEC on acceptance of a non-shift or illegal code; IDLE -> SHIFT on acceptance of SLL/SRL.
REQ-011 In EXEC, the ALU SHALL be driven from the registered operands for one cycle; the result is captured at the end of that cycle; EXEC -> RESP. Latency from accepting edge to rsp_valid: 2 edges.
REQ-012 SLT SHALL compute result = {15'b0, alu_result[15] ^ alu_overflow} from the SUB issue, because the ALU's less input is tied to 0.
REQ-013 SLL SHALL iterate shamt cycles in SHIFT, each driving ALU ADD with alu_a = alu_b = accumulator and capturing alu_result into the accumulator.
REQ-014 SRL SHALL iterate shamt cycles in SHIFT, each performing accumulator = {1'b0, accumulator[15:1]} locally; ALU inputs are driven 0 during SRL.
REQ-015 shamt=0 SHALL spend exactly one SHIFT cycle with the result equal to req_a; SHIFT -> RESP after max(shamt,1) cycles.
REQ-016 rsp_zero SHALL be 1 iff rsp_result==0; rsp_overflow and rsp_cout SHALL be the captured ALU flags for ADD/SUB only and 0 for all other ops.
REQ-017 An illegal code SHALL pass through EXEC with rsp_result=0, rsp_err=1 and all other flags 0.
REQ-018 In RESP, rsp_valid=1 and all rsp_* outputs SHALL be held stable until rsp_ready=1; on that edge the FSM goes to IDLE. There is no same-cycle re-accept.
REQ-019 When rsp_valid=0, rsp_* data SHALL hold their last value.

Reset
REQ-020 Reset SHALL force state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, all rsp flags 0, all alu_* outputs 0, and the accumulator and shift counter to 0, immediately and regardless of clk.
REQ-021 Reset mid-EXEC, mid-SHIFT or mid-RESP SHALL abandon the operation with no response produced.

Configuration
REQ-022 Macro ALU_ISSUE_SHIFT_EN: when defined, SLL/SRL behave per REQ-013..015.
REQ-023 When ALU_ISSUE_SHIFT_EN is undefined, SLL/SRL SHALL be treated as illegal (REQ-017), and the SHIFT state and shift counter SHALL be absent.

Structure
REQ-024 A shared package SHALL hold the ALU op encodings (AND=000, OR=001, ADD=010), the function-code constants and the FSM state typedef.
REQ-025 One sub-module, alu_func_decode, is natural: it is a combinational mapping from func to {op, ainvert, bnegate, cin, legal, is_shift}.

Verification
REQ-026 ADD a=0x7FFF b=0x0001 -> rsp_result=0x8000, overflow=1, cout=0, zero=0; rsp_valid 2 edges after accept.
REQ-027 SUB a=5 b=5 -> result=0x0000, zero=1, cout=1; then SLT a=0x8000 b=0x0001 -> result=0x0001.
REQ-028 SLL a=0x0003 shamt=4 -> result=0x0030 after 4 SHIFT cycles; SRL a=0x8000 shamt=15 -> 0x0001; SLL shamt=0 -> result=a.
REQ-029 Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; func=3 -> rsp_err=1, result=0.
REQ-030 Assert reset during SHIFT with shamt=10 -> outputs reach reset values immediately, no rsp_valid; next request completes normally.
